// File: rtl/dap_bridge.sv
// dap_bridge: MCU data access port to internal word bus bridge.
//
// Converts the MCU's asynchronous active-low CE/RE/WE strobes and 8-bit data
// bus into clocked word read/write requests. Each transaction begins with a
// command byte (bit0 INC, bit1 DIR), then ADDR_BYTES address bytes (LSB first),
// then data. Writes assemble DATA_BYTES bytes into a word and raise o_w_rq.
// Reads prefetch a word with o_r_rq and shift it out a byte per read strobe.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   io_dap_data   MCU data bus, driven only while CE and RE pins are both low
//   i_dap_ce_n    MCU chip enable, active-low, asynchronous
//   i_dap_re_n    MCU read strobe, active-low, asynchronous
//   i_dap_we_n    MCU write strobe, active-low, asynchronous
//   o_dap_rdy     high when the port accepts the next byte
//   o_addr        bus word address
//   o_d_wr        bus write word, byte 0 in bits [7:0]
//   i_d_rd        bus read word
//   o_w_rq        write request, held until acknowledged
//   o_r_rq        read request, held until acknowledged
//   i_rq_ack      bus acknowledge for the current request

module dap_bridge #(
  parameter int unsigned ADDR_BYTES  = 3,
  parameter int unsigned DATA_BYTES  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  inout  wire  [7:0]              io_dap_data,
  input  logic                    i_dap_ce_n,
  input  logic                    i_dap_re_n,
  input  logic                    i_dap_we_n,
  output logic                    o_dap_rdy,
  output logic [8*ADDR_BYTES-1:0] o_addr,
  output logic [8*DATA_BYTES-1:0] o_d_wr,
  input  logic [8*DATA_BYTES-1:0] i_d_rd,
  output logic                    o_w_rq,
  output logic                    o_r_rq,
  input  logic                    i_rq_ack
);

  localparam int unsigned AW       = 8 * ADDR_BYTES;
  localparam int unsigned DW       = 8 * DATA_BYTES;
  localparam int unsigned MaxBytes = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned CntW     = $clog2(MaxBytes + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StWreq,
    StRfetch,
    StRdata
  } state_e;

  // Synchronisers: strobes are inverted to active-high before the first flop.
  logic [SYNC_STAGES-1:0] r_ce_sync;
  logic [SYNC_STAGES-1:0] r_re_sync;
  logic [SYNC_STAGES-1:0] r_we_sync;
  logic [7:0]             r_data_sync [SYNC_STAGES];

  // One-cycle delayed copies for edge detection; r_byte lines up with r_we_d.
  logic       r_ce_d;
  logic       r_re_d;
  logic       r_we_d;
  logic [7:0] r_byte;

  logic w_ce;
  logic w_re;
  logic w_we;
  logic w_ce_rise;
  logic w_we_ev;
  logic w_re_ev;

  state_e r_state;
  state_e w_state_next;

  logic [CntW-1:0] r_cnt;
  logic            r_inc;
  logic            r_dir;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_d_wr;
  logic [DW-1:0]   r_shift;
  logic [7:0]      r_dout;

  logic            w_addr_last;
  logic            w_data_last;
  logic [AW-1:0]   w_addr_inc;
  logic [CntW-1:0] w_cnt_inc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ce_sync <= '0;
      r_re_sync <= '0;
      r_we_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= '0;
      end
      r_ce_d <= 1'b0;
      r_re_d <= 1'b0;
      r_we_d <= 1'b0;
      r_byte <= '0;
    end else begin
      r_ce_sync      <= {r_ce_sync[SYNC_STAGES-2:0], ~i_dap_ce_n};
      r_re_sync      <= {r_re_sync[SYNC_STAGES-2:0], ~i_dap_re_n};
      r_we_sync      <= {r_we_sync[SYNC_STAGES-2:0], ~i_dap_we_n};
      r_data_sync[0] <= io_dap_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= r_data_sync[i-1];
      end
      r_ce_d <= w_ce;
      r_re_d <= w_re;
      r_we_d <= w_we;
      r_byte <= r_data_sync[SYNC_STAGES-1];
    end
  end

  assign w_ce = r_ce_sync[SYNC_STAGES-1];
  assign w_re = r_re_sync[SYNC_STAGES-1];
  assign w_we = r_we_sync[SYNC_STAGES-1];

  // Byte events only count inside an active transaction. The write byte is
  // the data sample taken alongside the last asserted WE sample.
  assign w_ce_rise = w_ce & ~r_ce_d;
  assign w_we_ev   = r_we_d & ~w_we & w_ce;
  assign w_re_ev   = r_re_d & ~w_re & w_ce;

  assign w_addr_last = (r_cnt == CntW'(ADDR_BYTES - 1));
  assign w_data_last = (r_cnt == CntW'(DATA_BYTES - 1));
  assign w_addr_inc  = r_addr + AW'(1);
  assign w_cnt_inc   = r_cnt + CntW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request states never leave on CE loss: the bus cycle runs to its ack.
  always_comb begin
    w_state_next = r_state;
    o_w_rq       = 1'b0;
    o_r_rq       = 1'b0;
    o_dap_rdy    = 1'b1;
    case (r_state)
      StIdle: begin
        if (w_ce_rise) w_state_next = StCmd;
      end
      StCmd: begin
        if (!w_ce) w_state_next = StIdle;
        else if (w_we_ev) w_state_next = StAddr;
      end
      StAddr: begin
        if (!w_ce) w_state_next = StIdle;
        else if (w_we_ev && w_addr_last) w_state_next = r_dir ? StRfetch : StWdata;
      end
      StWdata: begin
        if (!w_ce) w_state_next = StIdle;
        else if (w_we_ev && w_data_last) w_state_next = StWreq;
      end
      StWreq: begin
        o_w_rq    = 1'b1;
        o_dap_rdy = 1'b0;
        if (i_rq_ack) w_state_next = w_ce ? StWdata : StIdle;
      end
      StRfetch: begin
        o_r_rq    = 1'b1;
        o_dap_rdy = 1'b0;
        if (i_rq_ack) w_state_next = w_ce ? StRdata : StIdle;
      end
      StRdata: begin
        if (!w_ce) w_state_next = StIdle;
        else if (w_re_ev && w_data_last) w_state_next = StRfetch;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_inc   <= 1'b0;
      r_dir   <= 1'b0;
      r_addr  <= '0;
      r_d_wr  <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_cnt <= '0;
        end
        StCmd: begin
          if (w_we_ev) begin
            r_inc <= r_byte[0];
            r_dir <= r_byte[1];
            r_cnt <= '0;
          end
        end
        StAddr: begin
          if (w_we_ev) begin
            for (int i = 0; i < ADDR_BYTES; i++) begin
              if (r_cnt == CntW'(i)) r_addr[8*i +: 8] <= r_byte;
            end
            r_cnt <= w_addr_last ? '0 : w_cnt_inc;
          end
        end
        StWdata: begin
          if (w_we_ev) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (r_cnt == CntW'(i)) r_d_wr[8*i +: 8] <= r_byte;
            end
            r_cnt <= w_data_last ? '0 : w_cnt_inc;
          end
        end
        StWreq: begin
          if (i_rq_ack && r_inc) r_addr <= w_addr_inc;
        end
        StRfetch: begin
          if (i_rq_ack) begin
            r_shift <= i_d_rd;
            r_cnt   <= '0;
          end
        end
        StRdata: begin
          if (w_re_ev) begin
            r_shift <= r_shift >> 8;
            r_cnt   <= w_data_last ? '0 : w_cnt_inc;
            if (w_data_last && r_inc) r_addr <= w_addr_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Output byte only moves while synced RE is idle, so the MCU never sees it
  // change under an active read strobe. Non-read phases present 8'h00.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout <= '0;
    end else if (!w_re) begin
      r_dout <= (r_state == StRdata) ? r_shift[7:0] : 8'h00;
    end
  end

  assign io_dap_data = (!i_dap_ce_n && !i_dap_re_n) ? r_dout : 8'hzz;
  assign o_addr      = r_addr;
  assign o_d_wr      = r_d_wr;

endmodule

// File: doc/dap_bridge.md
# dap_bridge

Parametrised successor to the AVR data access port. It converts the MCU's asynchronous 8-bit parallel strobes (CE/RE/WE) into clocked word requests on the internal bus. It sits between the MCU pins and the bus arbiter. Compared with the previous port, it adds:
- configurable address and data widths;
- a per-transaction command byte that selects direction and auto-increment;
- read prefetch with real `d_rd` data;
- a ready/busy pin;
- synchronous reset.

## Interface
Parameters:
- `ADDR_BYTES`, default 3: address bytes per transaction (1..4); `addr` width = 8*ADDR_BYTES.
- `DATA_BYTES`, default 2: bytes per bus word (1..4); `d_wr`/`d_rd` width = 8*DATA_BYTES.
- `SYNC_STAGES`, default 2: flip-flop stages on CE/RE/WE/data (2..3).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `dap_data`  inout  8  MCU data bus; driven only while `!dap_ce_n && !dap_re_n`, otherwise Z.
- `dap_ce_n`, `dap_re_n`, `dap_we_n`  in  1  MCU chip enable / read / write strobes, active-low, asynchronous.
- `dap_rdy`  out  1  high = port accepts next byte; low while a bus request is pending.
- `addr`  out  8*ADDR_BYTES  bus word address.
- `d_wr`  out  8*DATA_BYTES  write word, byte 0 in bits [7:0].
- `d_rd`  in  8*DATA_BYTES  read word from bus.
- `w_rq`, `r_rq`  out  1  write / read request, held until acknowledged.
- `rq_ack`  in  1  bus acknowledge for the current request.

## Operation
- **Synchronisation.** CE/RE/WE are inverted to active-high and pass through SYNC_STAGES flops. `dap_data` passes through the same depth of flops.
- **Byte events.** A write byte is taken on the falling edge of synced `we`, using the data flop that is aligned with it. A read byte is consumed on the falling edge of synced `re`.
- **Transaction start.** A transaction starts when synced `ce` rises.
- **Command byte.** The first written byte is the command:
  - bit0 INC: increment `addr` by 1 after each word.
  - bit1 DIR: 1 = read, 0 = write.
  - Bits 7:2 are ignored.
- **Address.** The next ADDR_BYTES writes load `addr`, LSB first.
- **Write path.** DATA_BYTES writes fill `d_wr`, LSB first. After the last byte:
  - `w_rq` is set and `dap_rdy` is cleared.
  - On ack, `dap_rdy` is set and `addr` is incremented if INC.
  - The next byte starts a new word.
- **Read path.** After the last address byte, `r_rq` is issued immediately (prefetch) and `dap_rdy` is cleared.
  - On ack, `d_rd` is latched into the shift register and `dap_rdy` is set.
  - The output byte is shift[7:0]; each consumed read shifts right by 8.
  - After DATA_BYTES reads, `addr` is incremented if INC and a new prefetch is issued.
- **Ignored strobes.** WE during a read transaction and RE during command/address/write phases are ignored; the output byte is then 8'h00.
- **States:**
  - IDLE → CMD on `ce` rise.
  - CMD → ADDR on the command byte.
  - ADDR → WDATA or RFETCH after ADDR_BYTES bytes.
  - WDATA → WREQ after DATA_BYTES bytes.
  - WREQ → WDATA on ack.
  - RFETCH → RDATA on ack.
  - RDATA → RFETCH after DATA_BYTES reads.
  - Any state → IDLE when synced `ce` is low, except WREQ/RFETCH, which hold the request until ack and then go to IDLE. A bus cycle is never aborted.
- **Counters.** The byte counter is sized to max(ADDR_BYTES, DATA_BYTES). The `addr` increment wraps modulo 2^(8*ADDR_BYTES); all-ones + 1 = 0.

## Timing
- **Reset values:**
  - `w_rq` = `r_rq` = 0, `dap_rdy` = 1.
  - `addr` = 0, `d_wr` = 0, read shift register = 0.
  - State = IDLE, synchroniser flops = inactive.
- **Strobe latency.** Strobe-to-event latency is SYNC_STAGES to SYNC_STAGES+1 clocks.
- **MCU pulse widths.** The MCU must keep each strobe low and high for at least SYNC_STAGES+2 clocks.
- **Request timing:**
  - `w_rq`/`r_rq` rise the clock after the event that completes the word.
  - A request stays high until the first edge that samples `rq_ack`=1, and falls after that edge.
  - `addr` and `d_wr` are stable for the whole time the request is high.
  - `d_rd` is captured at the ack edge.
  - `dap_rdy` rises on the same edge the request falls.
- **Zero-wait ack.** An ack already high when the request rises completes in exactly one request cycle.
- **Data output.** `dap_data` drive enable is combinational from the raw pins. The output byte register changes only when `re` is deasserted (synced).
- **Reset priority.** `rst` during a pending request drops the request immediately; reset overrides the no-abort rule.

## Test plan
- Write cmd 8'h01, addr 8'h56,8'h34,8'h12, data 8'hCD,8'hAB,8'h01,8'h00 → two `w_rq`:
  - first with `addr`=24'h123456, `d_wr`=16'hABCD;
  - second with `addr`=24'h123457, `d_wr`=16'h0001.
- Read cmd 8'h03, addr 24'h000010, bus returns 16'hBEEF then 16'hCAFE, ack delayed 5 clocks:
  - `dap_rdy` is low until the ack;
  - MCU reads EF,BE,FE,CA;
  - second `r_rq` has `addr`=24'h000011.
- Cmd 8'h00 (no INC) write of two words → both requests at the same `addr`.
- Address 24'hFFFFFF with INC write → the second word's `addr` is 24'h000000.
- CE deasserted while `w_rq` is pending with ack held off 10 clocks → `w_rq` stays high until ack, then IDLE; the next CE restarts at the command byte.
- `rst` pulse mid-address phase → all outputs return to reset values; the next transaction parses the command correctly.
